// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the I2C register back end.
// Regbank FSM encoding and default register count.
package i2c_pkg;

  localparam int NUM_REGS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WR_DATA,
    RD_DATA
  } rb_state_e;

endpackage

// File: rtl/i2c_reg_array.sv
// i2c_reg_array: NUM_REGS x 8 storage, I2C and user write ports.
// I2C port wins on a same-index collision; reads are combinational.
module i2c_reg_array
  import i2c_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  localparam int PTR_W    = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i2c_we_i,
  input  logic [PTR_W-1:0] i2c_idx_i,
  input  logic [7:0]       i2c_wdata_i,
  input  logic             usr_we_i,
  input  logic [PTR_W-1:0] usr_idx_i,
  input  logic [7:0]       usr_wdata_i,
  input  logic [PTR_W-1:0] tx_idx_i,
  output logic [7:0]       tx_rdata_o,
`ifdef I2C_REGBANK_WPROT_EN
  output logic             lock_o,
`endif
  output logic [7:0]       usr_rdata_o
);

  logic [7:0] regs_q [NUM_REGS];

  // register storage: I2C write has priority over user write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i2c_we_i && i2c_idx_i == PTR_W'(i))
          regs_q[i] <= i2c_wdata_i;
        else if (usr_we_i && usr_idx_i == PTR_W'(i))
          regs_q[i] <= usr_wdata_i;
      end
    end
  end

  assign tx_rdata_o  = regs_q[tx_idx_i];
  assign usr_rdata_o = regs_q[usr_idx_i];

`ifdef I2C_REGBANK_WPROT_EN
  assign lock_o = regs_q[NUM_REGS-1][0];
`endif

endmodule

// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: pointer/auto-increment register back end for I2C slave.
// Define I2C_REGBANK_WPROT_EN to make the top register an I2C write lock.
module i2c_slave_regbank
  import i2c_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  localparam int PTR_W    = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sta_i,
  input  logic             sto_i,
  input  logic             rw_i,
  input  logic             rx_wr_i,
  input  logic [7:0]       rx_data_i,
  input  logic             tx_rd_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic [PTR_W-1:0] usr_addr_i,
  input  logic             usr_we_i,
  input  logic [7:0]       usr_wdata_i,
  output logic [7:0]       usr_rdata_o,
  output logic             wr_pulse_o,
  output logic [PTR_W-1:0] wr_idx_o,
  output logic [PTR_W-1:0] ptr_o
);

  rb_state_e        state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_pulse_q;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_rdata;
  logic             wr_req, i2c_we;

`ifdef I2C_REGBANK_WPROT_EN
  logic lock;
  assign i2c_we = wr_req &&
    (!lock || ptr_q == PTR_W'(NUM_REGS-1));
`else
  assign i2c_we = wr_req;
`endif

  i2c_reg_array #(.NUM_REGS(NUM_REGS)) u_regs (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i2c_we_i   (i2c_we),
    .i2c_idx_i  (ptr_q),
    .i2c_wdata_i(rx_data_i),
    .usr_we_i   (usr_we_i),
    .usr_idx_i  (usr_addr_i),
    .usr_wdata_i(usr_wdata_i),
    .tx_idx_i   (ptr_q),
    .tx_rdata_o (tx_rdata),
`ifdef I2C_REGBANK_WPROT_EN
    .lock_o     (lock),
`endif
    .usr_rdata_o(usr_rdata_o)
  );

  // FSM next state, pointer update and write request
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_req  = 1'b0;
    if (sto_i) begin
      state_d = IDLE;
    end else if (sta_i) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (rx_wr_i) begin
            ptr_d   = rx_data_i[PTR_W-1:0];
            state_d = WR_DATA;
          end else if (tx_rd_i && rw_i) begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = RD_DATA;
          end
        end
        WR_DATA: begin
          if (rx_wr_i) begin
            wr_req = 1'b1;
            ptr_d  = ptr_q + PTR_W'(1);
          end
        end
        RD_DATA: begin
          if (tx_rd_i) ptr_d = ptr_q + PTR_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // tx_data is stale for one cycle whenever ptr or regs[ptr] moves
  always_comb begin
    wr_idx_d   = i2c_we ? ptr_q : wr_idx_q;
    tx_valid_d = !((ptr_d != ptr_q) || i2c_we ||
                   (usr_we_i && usr_addr_i == ptr_q));
  end

  // state, pointer and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wr_pulse_q <= i2c_we;
      wr_idx_q   <= wr_idx_d;
      tx_data_q  <= tx_rdata;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign wr_pulse_o = wr_pulse_q;
  assign wr_idx_o   = wr_idx_q;
  assign ptr_o      = ptr_q;

endmodule
